serial_add_sequencer: RTL

- Bit-serial multi-bit adder built around one instance of the team's single-bit full_adder cell (a, b, carryIn -> sum, carryOut).
- Captures two WIDTH-bit operands on a start handshake and feeds the cell one bit pair per clock, LSB first, while holding the carry in a flip-flop.
- Assembles the WIDTH-bit sum and reports completion.
- Small-area alternative to a ripple-carry chain, used where throughput is not critical.

---
 rtl/serial_add_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial WIDTH-bit adder using one full_adder cell; optional add/sub via SERIAL_ADD_SUB_EN
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carryIn,
  output logic sum,
  output logic carryOut
);
  assign sum      = a ^ b ^ carryIn;
  assign carryOut = (a & b) | (carryIn & (a ^ b));
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
  output logic             overflow,
`endif
  input  logic             carryIn,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic fa_s, fa_co, accept, sub_en;
`ifdef SERIAL_ADD_SUB_EN
  assign sub_en   = sub;
  assign overflow = ovf_q;
`else
  assign sub_en = 1'b0;
`endif
  assign ready    = (state_q == IDLE) || (state_q == DONE);
  assign busy     = state_q == ADD;
  assign done     = state_q == DONE;
  assign sum      = sum_q;
  assign carryOut = cout_q;
  assign accept   = start && ready;
  full_adder u_fa (
    .a       (a_q[0]),
    .b       (b_q[0]),
    .carryIn (c_q),
    .sum     (fa_s),
    .carryOut(fa_co)
  );
  // next-state: capture operands on accepted start, otherwise step one bit per ADD cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      state_d = ADD;
      a_d     = a;
      b_d     = sub_en ? ~b : b;
      c_d     = sub_en ? 1'b1 : carryIn;
      cnt_d   = '0;
    end else if (state_q == ADD) begin
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      c_d   = fa_co;
      sum_d = {fa_s, sum_q[WIDTH-1:1]};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = DONE;
        cout_d  = fa_co;
        ovf_d   = c_q ^ fa_co;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
